// File: rtl/matrix_ls_pkg.sv
// Shared types and sizing for the matrix load/store path between the LS unit and the scratchpad.
package matrix_ls_pkg;

  localparam int unsigned MAT_ROWS    = 4;
  localparam int unsigned MAT_ROW_W   = 64;
  localparam int unsigned SPAD_ADDR_W = 11;
  localparam int unsigned MRF_REG_W   = 5;
  localparam int unsigned STRIDE_W    = 32;
  localparam int unsigned LS_W        = 2;
  localparam int unsigned ROW_IDX_W   = $clog2(MAT_ROWS);

  typedef enum logic [LS_W-1:0] {
    LS_NONE  = 2'b00,
    LS_LOAD  = 2'b01,
    LS_STORE = 2'b10
  } matls_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mls_state_t;

  // Request fields the responder keeps for the whole matrix walk
  typedef struct packed {
    matls_op_t              op;
    logic [MRF_REG_W-1:0]   rd;
  } mls_cmd_t;

  function automatic logic is_mem_op(input logic [LS_W-1:0] ls);
    return (ls == LS_LOAD) || (ls == LS_STORE);
  endfunction

endpackage

// File: rtl/mls_addr_gen.sv
// Row counter and running scratchpad address for one strided matrix walk.
module mls_addr_gen
  import matrix_ls_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   advance,
  input  logic [SPAD_ADDR_W-1:0] base,
  input  logic [SPAD_ADDR_W-1:0] stride,
  output logic [SPAD_ADDR_W-1:0] addr,
  output logic [ROW_IDX_W-1:0]   row,
  output logic                   last
);

  logic [SPAD_ADDR_W-1:0] stride_q;

  // Address arithmetic wraps naturally at the scratchpad size
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      row      <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      row      <= '0;
      stride_q <= stride;
    end else if (advance) begin
      addr     <= addr + stride_q;
      row      <= row + ROW_IDX_W'(1);
    end
  end

  assign last = (row == ROW_IDX_W'(MAT_ROWS - 1));

endmodule

// File: rtl/scratchpad_ls_responder.sv
// Scratchpad-side responder: walks MAT_ROWS strided SRAM rows per LS request and signals completion on mhit.
module scratchpad_ls_responder
  import matrix_ls_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  input  logic [LS_W-1:0]        req_ls,
  input  logic [MRF_REG_W-1:0]   req_rd,
  input  logic [SPAD_ADDR_W-1:0] req_addr,
  input  logic [STRIDE_W-1:0]    req_stride,
  output logic                   mhit,
  output logic                   busy,
  output logic                   sram_ren,
  output logic                   sram_wen,
  output logic [SPAD_ADDR_W-1:0] sram_addr,
  output logic [MAT_ROW_W-1:0]   sram_wdata,
  input  logic [MAT_ROW_W-1:0]   sram_rdata,
  input  logic                   sram_ack,
  output logic [MRF_REG_W-1:0]   mrf_reg,
  output logic [ROW_IDX_W-1:0]   mrf_row,
  output logic                   mrf_wen,
  output logic [MAT_ROW_W-1:0]   mrf_wdata,
  input  logic [MAT_ROW_W-1:0]   mrf_rdata
);

  mls_state_t             state, next_state;
  mls_cmd_t               cmd_q;
  logic                   gen_load, gen_advance, gen_last;
  logic [SPAD_ADDR_W-1:0] gen_addr;
  logic [ROW_IDX_W-1:0]   gen_row;

  // Only the low address bits of the stride matter: the address space wraps
  logic unused_stride_bits;
  assign unused_stride_bits = ^req_stride[STRIDE_W-1:SPAD_ADDR_W];

  mls_addr_gen u_addr_gen (
    .clk     (CLK),
    .rst     (RST),
    .load    (gen_load),
    .advance (gen_advance),
    .base    (req_addr),
    .stride  (req_stride[SPAD_ADDR_W-1:0]),
    .addr    (gen_addr),
    .row     (gen_row),
    .last    (gen_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           cmd_q <= '0;
    else if (gen_load) cmd_q <= '{op: matls_op_t'(req_ls), rd: req_rd};
  end

  // Strobes and data paths are live only while REQ; everything else parks at zero
  always_comb begin
    next_state  = state;
    gen_load    = 1'b0;
    gen_advance = 1'b0;
    mhit        = 1'b0;
    busy        = 1'b0;
    sram_ren    = 1'b0;
    sram_wen    = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    mrf_reg     = '0;
    mrf_row     = '0;
    mrf_wen     = 1'b0;
    mrf_wdata   = '0;
    case (state)
      IDLE: begin
        if (req_valid && is_mem_op(req_ls)) begin
          gen_load   = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        busy      = 1'b1;
        sram_addr = gen_addr;
        mrf_reg   = cmd_q.rd;
        mrf_row   = gen_row;
        if (cmd_q.op == LS_LOAD) begin
          sram_ren  = 1'b1;
          mrf_wen   = sram_ack;
          mrf_wdata = sram_rdata;
        end else begin
          sram_wen   = 1'b1;
          sram_wdata = mrf_rdata;
        end
        if (sram_ack) begin
          if (gen_last) next_state  = DONE;
          else          gen_advance = 1'b1;
        end
      end
      DONE: begin
        busy = 1'b1;
        mhit = 1'b1;
        // Initiator must drop req_valid before a new request can be seen
        if (!req_valid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_scratchpad_ls_responder.sv
// Self-checking bench for scratchpad_ls_responder: directed table, hand-written corner sequences, random requests.
module tb_scratchpad_ls_responder;
  import matrix_ls_pkg::*;

  localparam int unsigned AW  = SPAD_ADDR_W;
  localparam int unsigned DW  = MAT_ROW_W;
  localparam int unsigned TMO = 100;
  localparam int unsigned NV  = 6;

  logic           CLK = 1'b0;
  logic           RST;
  logic           req_valid;
  logic [1:0]     req_ls;
  logic [4:0]     req_rd;
  logic [AW-1:0]  req_addr;
  logic [31:0]    req_stride;
  logic           mhit, busy, sram_ren, sram_wen, sram_ack, mrf_wen;
  logic [AW-1:0]  sram_addr;
  logic [DW-1:0]  sram_wdata, sram_rdata, mrf_wdata, mrf_rdata;
  logic [4:0]     mrf_reg;
  logic [ROW_IDX_W-1:0] mrf_row;

  int tests = 0;
  int fails = 0;

  // Environment: scratchpad, matrix register file, ack latency
  logic [DW-1:0] sram_mem [2048];
  logic [DW-1:0] mrf_mem  [128];
  logic [DW-1:0] ref_sram [2048];
  logic [DW-1:0] ref_mrf  [128];
  logic [1:0]    wait_tab [4];
  int            wait_cnt;
  logic          fill;

  always #5 CLK = ~CLK;

  scratchpad_ls_responder dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ls(req_ls), .req_rd(req_rd),
    .req_addr(req_addr), .req_stride(req_stride), .mhit(mhit), .busy(busy),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ack(sram_ack), .mrf_reg(mrf_reg), .mrf_row(mrf_row),
    .mrf_wen(mrf_wen), .mrf_wdata(mrf_wdata), .mrf_rdata(mrf_rdata)
  );

  assign sram_rdata = sram_mem[sram_addr];
  assign mrf_rdata  = mrf_mem[{mrf_reg, mrf_row}];
  assign sram_ack   = (sram_ren | sram_wen) && (wait_cnt >= int'(wait_tab[mrf_row]));

  always @(posedge CLK) begin
    if (fill) begin
      for (int i = 0; i < 2048; i++) sram_mem[i] <= {$urandom, $urandom};
      for (int i = 0; i < 128; i++)  mrf_mem[i]  <= {$urandom, $urandom};
    end else begin
      if (sram_wen && sram_ack) sram_mem[sram_addr] <= sram_wdata;
      if (mrf_wen) mrf_mem[{mrf_reg, mrf_row}] <= mrf_wdata;
    end
    if (RST || !(sram_ren | sram_wen) || sram_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  typedef struct packed {
    logic [1:0]         op;
    logic [4:0]         rd;
    logic [AW-1:0]      base;
    logic [31:0]        stride;
    logic [1:0]         wt;
    logic [2:0]         hold;
    logic [3:0][AW-1:0] addrs;
    logic [7:0]         cyc;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] rd, input logic [AW-1:0] base,
                              input logic [31:0] stride, input logic [1:0] wt, input logic [2:0] hold,
                              input int a0, input int a1, input int a2, input int a3, input int cyc);
    vec_t v;
    v.op = op; v.rd = rd; v.base = base; v.stride = stride; v.wt = wt; v.hold = hold;
    v.addrs[0] = AW'(a0); v.addrs[1] = AW'(a1); v.addrs[2] = AW'(a2); v.addrs[3] = AW'(a3);
    v.cyc = 8'(cyc);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{mhit, busy, sram_ren, sram_wen, sram_addr, sram_wdata, mrf_wen, mrf_reg, mrf_row, mrf_wdata};
  endfunction

  // Reference model: row k lives at (base + k*stride) mod 2^AW
  function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] base, input logic [31:0] stride, input int k);
    longint a;
    a = longint'(base) + longint'(k) * longint'(stride);
    return AW'(a % 2048);
  endfunction

  function automatic int ref_cycles();
    int c = 1;
    for (int k = 0; k < 4; k++) c += int'(wait_tab[k]) + 1;
    return c;
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [4:0] rd, input logic [AW-1:0] base,
                             input logic [31:0] stride, input int nrows);
    for (int k = 0; k < nrows; k++) begin
      if (op == 2'b01) ref_mrf[int'(rd) * 4 + k] = ref_sram[ref_addr(base, stride, k)];
      else             ref_sram[ref_addr(base, stride, k)] = ref_mrf[int'(rd) * 4 + k];
    end
  endtask

  task automatic check_mem(input string tag, input logic [1:0] op, input logic [4:0] rd,
                           input logic [AW-1:0] base, input logic [31:0] stride);
    for (int k = 0; k < 4; k++) begin
      if (op == 2'b01) check({tag, "_mrf_row"}, mrf_mem[int'(rd) * 4 + k], ref_mrf[int'(rd) * 4 + k]);
      else check({tag, "_sram_row"}, sram_mem[ref_addr(base, stride, k)], ref_sram[ref_addr(base, stride, k)]);
    end
  endtask

  task automatic run_txn(input string tag, input logic [1:0] op, input logic [4:0] rd, input logic [AW-1:0] base,
                         input logic [31:0] stride, input int hold, input logic [3:0][AW-1:0] exp_addrs,
                         input int exp_cyc);
    logic [AW-1:0] obs [$];
    int cyc = 0;
    int bad = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_ls = op; req_rd = rd; req_addr = base; req_stride = stride;
    @(posedge CLK);
    for (int k = 1; k <= int'(TMO); k++) begin
      @(negedge CLK);
      if (sram_ack) begin
        obs.push_back(sram_addr);
        if (sram_ren !== (op == 2'b01) || sram_wen !== (op == 2'b10) || mrf_reg !== rd) bad++;
      end
      if (mhit) begin
        cyc = k;
        break;
      end
    end
    check({tag, "_mhit_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_strobe_bad"}, 64'(bad), 64'd0);
    check({tag, "_access_cnt"}, 64'(obs.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      check({tag, "_addr"}, (k < obs.size()) ? 64'(obs[k]) : 64'hdead, 64'(exp_addrs[k]));
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check({tag, "_hold"}, 64'({mhit, busy, sram_ren, sram_wen}), 64'b1100);
    end
    req_valid = 1'b0;
    @(posedge CLK); #1;
    check({tag, "_idle"}, 64'({mhit, busy}), 64'd0);
    model_apply(op, rd, base, stride, 4);
    check_mem(tag, op, rd, base, stride);
  endtask

  initial begin
    logic [3:0][AW-1:0] ea;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [AW-1:0] base;
    logic [31:0] stride;
    int found;

    vecs[0] = mk(2'b01, 5'd3,  11'd100,  32'd5,          2'd0, 3'd4, 100, 105, 110, 115, 5);
    vecs[1] = mk(2'b10, 5'd7,  11'd55,   32'd1,          2'd2, 3'd1, 55, 56, 57, 58, 13);
    vecs[2] = mk(2'b01, 5'd1,  11'd2046, 32'd1,          2'd0, 3'd0, 2046, 2047, 0, 1, 5);
    vecs[3] = mk(2'b10, 5'd2,  11'd10,   32'h0000_0801,  2'd1, 3'd2, 10, 11, 12, 13, 9);
    vecs[4] = mk(2'b01, 5'd0,  11'd7,    32'd0,          2'd0, 3'd0, 7, 7, 7, 7, 5);
    vecs[5] = mk(2'b10, 5'd31, 11'd2000, 32'hFFFF_FFFF,  2'd0, 3'd1, 2000, 1999, 1998, 1997, 5);

    RST = 1'b1; fill = 1'b1; req_valid = 1'b0; req_ls = '0; req_rd = '0; req_addr = '0; req_stride = '0;
    for (int k = 0; k < 4; k++) wait_tab[k] = 2'd0;
    @(negedge CLK);
    check("reset_outputs", 64'(any_out()), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    fill = 1'b0; RST = 1'b0;
    ref_sram = sram_mem;
    ref_mrf  = mrf_mem;

    for (int i = 0; i < int'(NV); i++) begin
      for (int k = 0; k < 4; k++) wait_tab[k] = vecs[i].wt;
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].base, vecs[i].stride,
              int'(vecs[i].hold), vecs[i].addrs, int'(vecs[i].cyc));
    end

    // No-op encodings must be ignored entirely
    for (int n = 0; n < 2; n++) begin
      @(negedge CLK);
      req_valid = 1'b1; req_ls = (n == 0) ? 2'b00 : 2'b11;
      for (int c = 0; c < 3; c++) begin
        @(negedge CLK);
        check("noop_quiet", 64'({busy, mhit, sram_ren, sram_wen}), 64'd0);
      end
      req_valid = 1'b0;
    end

    // Reset during row 2 of a LOAD leaves rows 0-1 written, nothing else
    for (int k = 0; k < 4; k++) wait_tab[k] = 2'd0;
    @(negedge CLK);
    req_valid = 1'b1; req_ls = 2'b01; req_rd = 5'd9; req_addr = 11'd300; req_stride = 32'd3;
    @(posedge CLK);
    found = 0;
    for (int k = 0; k < int'(TMO); k++) begin
      @(negedge CLK);
      if (sram_ren && mrf_row == 2'd2) begin
        found = 1;
        break;
      end
    end
    check("rst_reach_row2", 64'(found), 64'd1);
    RST = 1'b1;
    #1;
    check("rst_outputs_zero", 64'(any_out()), 64'd0);
    req_valid = 1'b0;
    @(negedge CLK);
    check("rst_no_mhit", 64'({mhit, busy}), 64'd0);
    RST = 1'b0;
    model_apply(2'b01, 5'd9, 11'd300, 32'd3, 2);
    check_mem("rst_partial", 2'b01, 5'd9, 11'd300, 32'd3);
    for (int k = 0; k < 4; k++) ea[k] = ref_addr(11'd300, 32'd3, k);
    run_txn("rst_restart", 2'b01, 5'd9, 11'd300, 32'd3, 0, ea, 5);

    // Random requests against the reference model
    for (int t = 0; t < 16; t++) begin
      op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      rd = 5'($urandom_range(0, 31));
      base = AW'($urandom);
      stride = $urandom;
      if (t % 4 == 0) stride = 32'($urandom_range(0, 2));
      for (int k = 0; k < 4; k++) begin
        wait_tab[k] = 2'($urandom_range(0, 2));
        ea[k] = ref_addr(base, stride, k);
      end
      run_txn($sformatf("rand%0d", t), op, rd, base, stride, int'($urandom_range(0, 3)), ea, ref_cycles());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
